// File: rtl/game_seq_ctrl.sv
// game_seq_ctrl: debounced select plus IDLE/PLAY/PAUSE/OVER game sequencer with step, BCD score, lives and speed (pause via GAME_PAUSE_EN)
module game_seq_ctrl #(
    parameter int DEB_CYCLES   = 1000000,
    parameter int LIVES        = 3,
    parameter int START_PERIOD = 30,
    parameter int MIN_PERIOD   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       frame_tick,
    input  logic       point,
    input  logic       collision,
    output logic [1:0] state,
    output logic       step,
    output logic [7:0] score_bcd,
    output logic [2:0] lives,
    output logic [5:0] period,
    output logic       press
);
    localparam int cw = $clog2(DEB_CYCLES);
    typedef enum logic [1:0] {IDLE, PLAY, PAUSE, OVER} state_t;
    state_t st;
    logic s1, sel_s, sel_db, db_q;
    logic [cw-1:0] deb_cnt;
    logic [5:0] frame_cnt;
    assign state = st;
    always_ff @(posedge clk) begin
        if (rst) begin
            {s1, sel_s, sel_db, db_q, press} <= '0;
            deb_cnt <= '0;
        end else begin
            s1 <= sel;
            sel_s <= s1;
            db_q <= sel_db;
            press <= sel_db & ~db_q;
            if (sel_s == sel_db) deb_cnt <= '0;
            else if (deb_cnt == cw'(DEB_CYCLES - 1)) begin
                sel_db <= sel_s;
                deb_cnt <= '0;
            end else deb_cnt <= deb_cnt + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            step <= 1'b0;
            score_bcd <= 8'h00;
            lives <= 3'(LIVES);
            period <= 6'(START_PERIOD);
            frame_cnt <= 6'd0;
        end else begin
            step <= 1'b0;
            case (st)
                IDLE: if (press) begin
                    st <= PLAY;
                    score_bcd <= 8'h00;
                    lives <= 3'(LIVES);
                    period <= 6'(START_PERIOD);
                    frame_cnt <= 6'd0;
                end
                PLAY: begin
                    if (frame_tick) begin
                        step <= frame_cnt == period - 6'd1;
                        frame_cnt <= (frame_cnt == period - 6'd1) ? 6'd0 : frame_cnt + 6'd1;
                    end
                    if (point && score_bcd != 8'h99) begin
                        score_bcd <= (score_bcd[3:0] == 4'd9) ? {score_bcd[7:4] + 4'd1, 4'd0} : score_bcd + 8'd1;
                        if (score_bcd[3:0] == 4'd9 && period != 6'(MIN_PERIOD)) period <= period - 6'd1;
                    end
                    if (collision) begin
                        lives <= lives - 3'd1;
                        if (lives == 3'd1) st <= OVER;
                    end
`ifdef GAME_PAUSE_EN
                    else if (press) st <= PAUSE;
`endif
                end
                PAUSE: if (press) st <= PLAY;
                OVER: if (press) st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_game_seq_ctrl.sv
// tb_game_seq_ctrl: directed and randomized checks of game_seq_ctrl against a behavioural model
module tb_game_seq_ctrl;
    localparam int DEB = 4;
    localparam int LV = 3;
    localparam int SP = 3;
    localparam int MP = 2;
`ifdef GAME_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, sel = 1'b0, frame_tick = 1'b0, point = 1'b0, collision = 1'b0;
    logic [1:0] state;
    logic step;
    logic [7:0] score_bcd;
    logic [2:0] lives;
    logic [5:0] period;
    logic press;
    int n_chk = 0, n_fail = 0;
    int m_state, m_score, m_lives, m_period, m_fcnt;
    bit m_step, m_press, m_db, m_rose;
    bit hist[$];

    game_seq_ctrl #(.DEB_CYCLES(DEB), .LIVES(LV), .START_PERIOD(SP), .MIN_PERIOD(MP)) dut (
        .clk(clk), .rst(rst), .sel(sel), .frame_tick(frame_tick), .point(point),
        .collision(collision), .state(state), .step(step), .score_bcd(score_bcd),
        .lives(lives), .period(period), .press(press)
    );

    always #2 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit pr, f;
        if (rst) begin
            m_state = 0; m_score = 0; m_lives = LV; m_period = SP; m_fcnt = 0;
            m_step = 0; m_press = 0; m_db = 0; m_rose = 0;
            hist = {};
            repeat (DEB + 2) hist.push_back(1'b0);
        end else begin
            pr = m_press;
            m_step = 0;
            case (m_state)
                0: if (pr) begin
                    m_state = 1; m_score = 0; m_lives = LV; m_period = SP; m_fcnt = 0;
                end
                1: begin
                    if (frame_tick) begin
                        if (m_fcnt == m_period - 1) begin m_step = 1; m_fcnt = 0; end
                        else m_fcnt = (m_fcnt + 1) % 64;
                    end
                    if (point && m_score < 99) begin
                        if (m_score % 10 == 9 && m_period != MP) m_period--;
                        m_score++;
                    end
                    if (collision) begin
                        m_lives--;
                        if (m_lives == 0) m_state = 3;
                    end else if (pr && PAUSE_EN) m_state = 2;
                end
                2: if (pr) m_state = 1;
                default: if (pr) m_state = 0;
            endcase
            // debounced level flips once DEB consecutive synchronized samples disagree with it
            hist.push_back(sel);
            void'(hist.pop_front());
            f = 1;
            for (int j = 2; j <= DEB + 1; j++) if (hist[hist.size() - 1 - j] == m_db) f = 0;
            m_press = m_rose;
            m_rose = f && !m_db;
            if (f) m_db = !m_db;
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit ft, input bit pt, input bit co);
        rst = r; sel = s; frame_tick = ft; point = pt; collision = co;
        @(posedge clk);
        model_edge();
        #1;
        chk("state", state, 8'(m_state));
        chk("step", step, 8'(m_step));
        chk("score", score_bcd, 8'((m_score / 10) * 16 + m_score % 10));
        chk("lives", lives, 8'(m_lives));
        chk("period", period, 8'(m_period));
        chk("press", press, 8'(m_press));
    endtask

    task automatic do_press();
        int n = 0;
        bit seen = 0;
        while (!seen && n < 20) begin
            cyc(0, 1, 0, 0, 0);
            n++;
            seen = press;
        end
        chk("press_seen", 8'(seen), 8'd1);
        cyc(0, 1, 0, 0, 0);
        repeat (DEB + 4) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        int n, steps, len;
        bit lvl;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst_state", state, 8'd0);
        chk("rst_score", score_bcd, 8'h00);
        chk("rst_lives", lives, 8'd3);
        chk("rst_period", period, 8'd3);
        repeat (4) begin
            cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
            cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        end
        repeat (4) cyc(0, 0, 0, 0, 0);
        chk("glitch_state", state, 8'd0);
        n = 0;
        do begin
            cyc(0, 1, 0, 0, 0);
            n++;
        end while (press !== 1'b1 && n < 20);
        chk("press_latency", 8'(n), 8'(DEB + 3));
        cyc(0, 1, 0, 0, 0);
        chk("play_entry", state, 8'd1);
        repeat (DEB + 4) cyc(0, 0, 0, 0, 0);
        steps = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 1, 0, 0); steps += int'(step);
            cyc(0, 0, 0, 0, 0); steps += int'(step);
        end
        chk("step_count", 8'(steps), 8'd3);
        repeat (10) cyc(0, 0, 0, 1, 0);
        chk("score_10", score_bcd, 8'h10);
        chk("period_10", period, 8'd2);
        repeat (10) cyc(0, 0, 0, 1, 0);
        chk("score_20", score_bcd, 8'h20);
        chk("period_20", period, 8'd2);
        repeat (80) cyc(0, 0, 0, 1, 0);
        chk("score_sat", score_bcd, 8'h99);
`ifdef GAME_PAUSE_EN
        do_press();
        chk("paused", state, 8'd2);
        steps = 0;
        repeat (6) begin cyc(0, 0, 1, 1, 1); steps += int'(step); end
        chk("pause_steps", 8'(steps), 8'd0);
        do_press();
        chk("resumed", state, 8'd1);
`endif
        cyc(0, 0, 0, 0, 1);
        chk("lives_2", lives, 8'd2);
        cyc(0, 0, 0, 0, 1);
        chk("lives_1", lives, 8'd1);
        cyc(0, 0, 0, 0, 1);
        chk("lives_0", lives, 8'd0);
        chk("over", state, 8'd3);
        do_press();
        chk("back_idle", state, 8'd0);
        lvl = 0;
        len = 0;
        for (int i = 0; i < 4000; i++) begin
            if (len == 0) begin
                lvl = 1'($urandom_range(0, 1));
                len = $urandom_range(1, 10);
            end
            len--;
            cyc($urandom_range(0, 599) == 0, lvl, $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
